// File: rtl/lsu_axi_master_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// lsu_axi_master_pkg : shared FSM encoding, AXI response and LSU size codes
// Revision: 1.0
// ---------------------------------------------------------------------------
package lsu_axi_master_pkg;

  localparam int OPT_WIDTH = 3;

  localparam logic [OPT_WIDTH-1:0] OPT_LSU_SB = 3'b001;
  localparam logic [OPT_WIDTH-1:0] OPT_LSU_SH = 3'b010;
  localparam logic [OPT_WIDTH-1:0] OPT_LSU_SW = 3'b100;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RD_ADDR = 3'd1,
    ST_RD_DATA = 3'd2,
    ST_WR_REQ  = 3'd3,
    ST_WR_RESP = 3'd4
  } state_t;

  function automatic logic resp_is_err(input logic [1:0] resp);
    return (resp == RESP_SLVERR) || (resp == RESP_DECERR);
  endfunction

endpackage
`default_nettype wire

// File: rtl/lsu_axi_master.sv
`default_nettype none
// ---------------------------------------------------------------------------
// lsu_axi_master : single-outstanding AXI4-Lite master for core loads/stores
// Revision: 1.0
// ---------------------------------------------------------------------------
module lsu_axi_master
  import lsu_axi_master_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int OPT_W  = OPT_WIDTH
) (
  input  logic              M_AXI_ACLK,
  input  logic              M_AXI_ARESET,

  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_wen,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [OPT_W-1:0]  req_size,

  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,

  output logic [ADDR_W-1:0] M_AXI_ARADDR,
  output logic              M_AXI_ARVALID,
  input  logic              M_AXI_ARREADY,

  input  logic [DATA_W-1:0] M_AXI_RDATA,
  input  logic [1:0]        M_AXI_RRESP,
  input  logic              M_AXI_RVALID,
  output logic              M_AXI_RREADY,

  output logic [ADDR_W-1:0] M_AXI_AWADDR,
  output logic              M_AXI_AWVALID,
  input  logic              M_AXI_AWREADY,

  output logic [DATA_W-1:0] M_AXI_WDATA,
  output logic [OPT_W-1:0]  M_AXI_WSTRB,
  output logic              M_AXI_WVALID,
  input  logic              M_AXI_WREADY,

  input  logic [1:0]        M_AXI_BRESP,
  input  logic              M_AXI_BVALID,
  output logic              M_AXI_BREADY
);

  state_t            state;
  state_t            state_nx;
  logic              aw_done;
  logic              w_done;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [OPT_W-1:0]  size_q;

  logic accept;
  logic ar_hs;
  logic r_hs;
  logic aw_hs;
  logic w_hs;
  logic b_hs;

  assign req_ready     = (state == ST_IDLE);
  assign accept        = req_valid && req_ready;

  // All VALID/READY outputs decode from state so reset clears them in one cycle.
  assign M_AXI_ARVALID = (state == ST_RD_ADDR);
  assign M_AXI_RREADY  = (state == ST_RD_DATA);
  assign M_AXI_AWVALID = (state == ST_WR_REQ) && !aw_done;
  assign M_AXI_WVALID  = (state == ST_WR_REQ) && !w_done;
  assign M_AXI_BREADY  = (state == ST_WR_RESP);

  assign M_AXI_ARADDR  = addr_q;
  assign M_AXI_AWADDR  = addr_q;
  assign M_AXI_WDATA   = wdata_q;
  assign M_AXI_WSTRB   = size_q;

  assign ar_hs = M_AXI_ARVALID && M_AXI_ARREADY;
  assign r_hs  = M_AXI_RVALID  && M_AXI_RREADY;
  assign aw_hs = M_AXI_AWVALID && M_AXI_AWREADY;
  assign w_hs  = M_AXI_WVALID  && M_AXI_WREADY;
  assign b_hs  = M_AXI_BVALID  && M_AXI_BREADY;

  always_ff @(posedge M_AXI_ACLK) begin
    if (M_AXI_ARESET) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:    if (accept) state_nx = req_wen ? ST_WR_REQ : ST_RD_ADDR;
      ST_RD_ADDR: if (ar_hs)  state_nx = ST_RD_DATA;
      ST_RD_DATA: if (r_hs)   state_nx = ST_IDLE;
      // AW and W complete independently; either may finish first.
      ST_WR_REQ:  if ((aw_done || aw_hs) && (w_done || w_hs)) state_nx = ST_WR_RESP;
      ST_WR_RESP: if (b_hs)   state_nx = ST_IDLE;
      default:    state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge M_AXI_ACLK) begin
    if (M_AXI_ARESET) begin
      addr_q    <= '0;
      wdata_q   <= '0;
      size_q    <= '0;
      aw_done   <= 1'b0;
      w_done    <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      if (accept) begin
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
        size_q  <= req_size;
        aw_done <= 1'b0;
        w_done  <= 1'b0;
      end else begin
        if (aw_hs) aw_done <= 1'b1;
        if (w_hs)  w_done  <= 1'b1;
      end
      rsp_valid <= r_hs || b_hs;
      if (r_hs) begin
        rsp_rdata <= M_AXI_RDATA;
        rsp_err   <= resp_is_err(M_AXI_RRESP);
      end else if (b_hs) begin
        rsp_err   <= resp_is_err(M_AXI_BRESP);
      end else begin
        rsp_err   <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: doc/lsu_axi_master.md
LSU_AXI_MASTER -- requirements
Module: lsu_axi_master

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, address width (equal to `ysyx_23060124_ISA_ADDR_WIDTH).
REQ-002 SHALL have parameter DATA_W, default 32, data width (equal to `ysyx_23060124_ISA_WIDTH).
REQ-003 SHALL have parameter OPT_W, default `ysyx_23060124_OPT_WIDTH, LSU size-code width carried on WSTRB.
REQ-004 SHALL have one clock and a synchronous, active-high reset; ports listed below.
REQ-005 M_AXI_ACLK  in  1  sole clock; all logic on rising edge.
REQ-006 M_AXI_ARESET  in  1  synchronous active-high reset.
REQ-007 req_valid in 1 / req_ready out 1: core request handshake.
REQ-008 req_wen in 1 (1 = store, 0 = load); req_addr in ADDR_W; req_wdata in DATA_W; req_size in OPT_W (`ysyx_23060124_OPT_LSU_SB/SH/SW).
REQ-009 rsp_valid out 1 (single-cycle pulse); rsp_rdata out DATA_W; rsp_err out 1.
REQ-010 Read address: M_AXI_ARADDR out ADDR_W, M_AXI_ARVALID out 1, M_AXI_ARREADY in 1.
REQ-011 Read data: M_AXI_RDATA in DATA_W, M_AXI_RRESP in 2, M_AXI_RVALID in 1, M_AXI_RREADY out 1.
REQ-012 Write address: M_AXI_AWADDR out ADDR_W, M_AXI_AWVALID out 1, M_AXI_AWREADY in 1.
REQ-013 Write data: M_AXI_WDATA out DATA_W, M_AXI_WSTRB out OPT_W, M_AXI_WVALID out 1, M_AXI_WREADY in 1.
REQ-014 Write response: M_AXI_BRESP in 2, M_AXI_BVALID in 1, M_AXI_BREADY out 1.

Function
REQ-015 FSM states: IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP; one transaction outstanding maximum.
REQ-016 req_ready SHALL be 1 only in IDLE; accept on req_valid && req_ready, registering addr/wdata/size/wen.
REQ-017 Accept at cycle T: load -> RD_ADDR with ARVALID=1 at T+1; store -> WR_REQ with AWVALID=WVALID=1 at T+1.
REQ-018 Every VALID SHALL stay high with stable payload until its READY is sampled high; then deasserts next cycle.
REQ-019 WR_REQ: AW and W accepted independently (same or different cycles); each VALID drops after its own handshake; move to WR_RESP once both done.
REQ-020 M_AXI_WSTRB SHALL carry the registered req_size code unchanged; AWADDR/WDATA unaligned data unmodified.
REQ-021 RD_ADDR -> RD_DATA on ARVALID && ARREADY; RREADY=1 throughout RD_DATA and WR_RESP has BREADY=1; no other cycle asserts them.
REQ-022 On RVALID && RREADY: register RDATA into rsp_rdata, pulse rsp_valid next cycle, return to IDLE.
REQ-023 On BVALID && BREADY: pulse rsp_valid next cycle, rsp_rdata holds previous value, return to IDLE.
REQ-024 rsp_err = 1 with rsp_valid iff captured RRESP/BRESP is 2'b10 or 2'b11; 2'b00 and 2'b01 are success.
REQ-025 req_ready SHALL be 0 in the cycle rsp_valid pulses only if not yet in IDLE; back-to-back request accepted in the rsp_valid cycle.
REQ-026 RVALID/BVALID arriving in a state not expecting them SHALL be ignored (READY stays 0).
REQ-027 Unbounded slave stalls SHALL be tolerated; no timeout.

Reset
REQ-028 Reset SHALL force IDLE, all M_AXI VALID/READY outputs 0, rsp_valid 0, rsp_err 0, rsp_rdata 0, address/data regs 0.
REQ-029 Reset mid-transaction SHALL abandon it: all VALIDs low the cycle after reset sampled, no rsp_valid produced.

Structure
REQ-030 FSM state enum and RESP code constants SHALL live in para_defines.v; LSU size codes reused from there.
REQ-031 Single flat module; no sub-modules.

Verification
REQ-032 Load addr 0x8000_0010, slave ARREADY 1 cycle late, RDATA 0xDEAD_BEEF RRESP 2'b01 -> one rsp_valid, rsp_rdata 0xDEADBEEF, rsp_err 0.
REQ-033 Store 0x8000_0004 data 0x1234_5678 size SW, AWREADY at +1, WREADY at +3 -> AWVALID drops first, WVALID holds to +3, one BREADY handshake, rsp_valid once.
REQ-034 Load with RRESP 2'b10 -> rsp_valid with rsp_err 1; next store with BRESP 2'b00 -> rsp_err 0.
REQ-035 Back-to-back load then store, req_valid held high -> second accepted in rsp_valid cycle, exactly two AXI transactions.
REQ-036 Reset asserted while ARVALID high and ARREADY held 0 -> ARVALID 0 next cycle, state IDLE, no rsp_valid.
REQ-037 Spurious BVALID=1 during load -> BREADY stays 0, load completes normally.
